// File: rtl/fetch_ifid_stage.sv
// Fetch PC register and IF/ID latch for the 16-bit WISC pipeline: stall hold,
// EX redirect flush, HALT parking and a saturating stall-cycle counter.
module fetch_ifid_stage #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   RESET_PC  = 16'h0000,
    parameter logic [WIDTH-1:0]   NOP_INSTR = 16'h0800,
    parameter logic [4:0]         HALT_OPC  = 5'b00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic [WIDTH-1:0] imem_instr_i,
    input  logic             imem_valid_i,
    output logic [WIDTH-1:0] imem_addr_o,
    output logic             imem_en_o,
    output logic [WIDTH-1:0] if_id_instr_o,
    output logic [WIDTH-1:0] if_id_pc2_o,
    output logic             if_id_valid_o,
    output logic             halted_o,
    output logic [15:0]      stall_cnt_o
);

    // Two-state fetch FSM; halted_o is the registered state and doubles as its debug view.
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc2_q, pc2_d;
    logic             valid_q, valid_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] pc_plus2;

    assign pc_plus2 = pc_q + WIDTH'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc2_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fetch handshake: imem_en_o requests the word at imem_addr_o; a word is
    // consumed on a clock edge only when imem_en_o and imem_valid_i are both high.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (redirect_i) begin
            pc_d    = {redirect_pc_i[WIDTH-1:1], 1'b0};
            instr_d = NOP_INSTR;
            pc2_d   = '0;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (stall_i) begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else if (state_q == HALTED || !imem_valid_i) begin
            instr_d = NOP_INSTR;
            pc2_d   = '0;
            valid_d = 1'b0;
        end else begin
            // HALT itself is latched valid so it retires; the PC parks on it.
            instr_d = imem_instr_i;
            pc2_d   = pc_plus2;
            valid_d = 1'b1;
            if (imem_instr_i[WIDTH-1:WIDTH-5] == HALT_OPC) state_d = HALTED;
            else                                          pc_d    = pc_plus2;
        end
    end

    assign imem_addr_o   = pc_q;
    assign imem_en_o     = (state_q == RUN) & ~stall_i & ~redirect_i;
    assign if_id_instr_o = instr_q;
    assign if_id_pc2_o   = pc2_q;
    assign if_id_valid_o = valid_q;
    assign halted_o      = (state_q == HALTED);
    assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed testbench for fetch_ifid_stage: reset, fetch stream, stall, redirect,
// memory-not-ready bubbles, HALT parking, PC wrap and asynchronous reset.
module tb_fetch_ifid_stage;

    localparam logic [15:0] ADDI = 16'h4321;
    localparam logic [15:0] NOP  = 16'h0800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic [15:0] imem_instr_i;
    logic        imem_valid_i;
    logic [15:0] imem_addr_o;
    logic        imem_en_o;
    logic [15:0] if_id_instr_o;
    logic [15:0] if_id_pc2_o;
    logic        if_id_valid_o;
    logic        halted_o;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    fetch_ifid_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_instr_i  (imem_instr_i),
        .imem_valid_i  (imem_valid_i),
        .imem_addr_o   (imem_addr_o),
        .imem_en_o     (imem_en_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc2_o   (if_id_pc2_o),
        .if_id_valid_o (if_id_valid_o),
        .halted_o      (halted_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_instr_i = ADDI; imem_valid_i = 1'b1;
        #12;
        checks++;
        if ({imem_addr_o, if_id_instr_o, if_id_pc2_o, if_id_valid_o, halted_o, stall_cnt_o, imem_en_o}
            !== {16'h0000, NOP, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: addr=%h instr=%h pc2=%h v=%b h=%b cnt=%h en=%b, expected 0000 0800 0000 0 0 0000 1",
                     imem_addr_o, if_id_instr_o, if_id_pc2_o, if_id_valid_o, halted_o, stall_cnt_o, imem_en_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_stream();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if ({imem_addr_o, if_id_pc2_o, if_id_instr_o, if_id_valid_o} !== {16'(2*i+2-2), 16'(2*i), ADDI, 1'b1}) begin
                errors++;
                $display("FAIL fetch_%0d: addr=%h pc2=%h instr=%h v=%b, expected addr=%h pc2=%h instr=%h v=1",
                         i, imem_addr_o, if_id_pc2_o, if_id_instr_o, if_id_valid_o, 16'(2*i), 16'(2*i), ADDI);
            end
        end
    endtask

    // Entered with pc=6 and IF/ID holding {ADDI, pc2=6}.
    task automatic test_stall();
        stall_i = 1'b1;
        #1;
        checks++;
        if (imem_en_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_en: en=%b, expected 0", imem_en_o);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if ({imem_addr_o, if_id_pc2_o, if_id_instr_o, if_id_valid_o, stall_cnt_o, imem_en_o}
                !== {16'h0006, 16'h0006, ADDI, 1'b1, 16'(i), 1'b0}) begin
                errors++;
                $display("FAIL stall_%0d: addr=%h pc2=%h instr=%h v=%b cnt=%0d en=%b, expected 0006 0006 %h 1 %0d 0",
                         i, imem_addr_o, if_id_pc2_o, if_id_instr_o, if_id_valid_o, stall_cnt_o, imem_en_o, ADDI, i);
            end
        end
    endtask

    task automatic test_redirect_over_stall();
        redirect_i = 1'b1; redirect_pc_i = 16'h0041; stall_i = 1'b1;
        step();
        checks++;
        if ({imem_addr_o, if_id_instr_o, if_id_pc2_o, if_id_valid_o, stall_cnt_o}
            !== {16'h0040, NOP, 16'h0000, 1'b0, 16'd3}) begin
            errors++;
            $display("FAIL redirect_stall: addr=%h instr=%h pc2=%h v=%b cnt=%0d, expected 0040 0800 0000 0 3",
                     imem_addr_o, if_id_instr_o, if_id_pc2_o, if_id_valid_o, stall_cnt_o);
        end
        redirect_i = 1'b0; stall_i = 1'b0;
        step();
        checks++;
        if ({imem_addr_o, if_id_pc2_o, if_id_valid_o} !== {16'h0042, 16'h0042, 1'b1}) begin
            errors++;
            $display("FAIL redirect_target: addr=%h pc2=%h v=%b, expected 0042 0042 1",
                     imem_addr_o, if_id_pc2_o, if_id_valid_o);
        end
    endtask

    task automatic test_imem_not_ready();
        imem_valid_i = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if ({imem_addr_o, if_id_instr_o, if_id_valid_o} !== {16'h0042, NOP, 1'b0}) begin
                errors++;
                $display("FAIL not_ready_%0d: addr=%h instr=%h v=%b, expected 0042 0800 0",
                         i, imem_addr_o, if_id_instr_o, if_id_valid_o);
            end
        end
        imem_valid_i = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if ({imem_addr_o, if_id_pc2_o, if_id_valid_o} !== {16'(16'h0042 + 2*i), 16'(16'h0042 + 2*i), 1'b1}) begin
                errors++;
                $display("FAIL resume_%0d: addr=%h pc2=%h v=%b, expected %h %h 1",
                         i, imem_addr_o, if_id_pc2_o, if_id_valid_o, 16'(16'h0042 + 2*i), 16'(16'h0042 + 2*i));
            end
        end
    endtask

    // Entered with pc=0046.
    task automatic test_halt();
        imem_instr_i = 16'h0000;
        step();
        checks++;
        if ({if_id_instr_o, if_id_pc2_o, if_id_valid_o, imem_addr_o, halted_o, imem_en_o}
            !== {16'h0000, 16'h0048, 1'b1, 16'h0046, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL halt_fetch: instr=%h pc2=%h v=%b addr=%h h=%b en=%b, expected 0000 0048 1 0046 1 0",
                     if_id_instr_o, if_id_pc2_o, if_id_valid_o, imem_addr_o, halted_o, imem_en_o);
        end
        imem_instr_i = ADDI;
        step();
        checks++;
        if ({if_id_instr_o, if_id_valid_o, imem_addr_o, halted_o} !== {NOP, 1'b0, 16'h0046, 1'b1}) begin
            errors++;
            $display("FAIL halt_parked: instr=%h v=%b addr=%h h=%b, expected 0800 0 0046 1",
                     if_id_instr_o, if_id_valid_o, imem_addr_o, halted_o);
        end
        redirect_i = 1'b1; redirect_pc_i = 16'h0010;
        step();
        redirect_i = 1'b0;
        #1;
        checks++;
        if ({halted_o, imem_addr_o, if_id_valid_o, imem_en_o} !== {1'b0, 16'h0010, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL halt_redirect: h=%b addr=%h v=%b en=%b, expected 0 0010 0 1",
                     halted_o, imem_addr_o, if_id_valid_o, imem_en_o);
        end
        step();
        checks++;
        if ({if_id_pc2_o, if_id_valid_o, imem_addr_o} !== {16'h0012, 1'b1, 16'h0012}) begin
            errors++;
            $display("FAIL halt_resume: pc2=%h v=%b addr=%h, expected 0012 1 0012",
                     if_id_pc2_o, if_id_valid_o, imem_addr_o);
        end
    endtask

    task automatic test_pc_wrap();
        redirect_i = 1'b1; redirect_pc_i = 16'hFFFF;
        step();
        redirect_i = 1'b0;
        checks++;
        if (imem_addr_o !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_target: addr=%h, expected fffe", imem_addr_o);
        end
        step();
        checks++;
        if ({imem_addr_o, if_id_pc2_o, if_id_valid_o} !== {16'h0000, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL wrap_fetch: addr=%h pc2=%h v=%b, expected 0000 0000 1",
                     imem_addr_o, if_id_pc2_o, if_id_valid_o);
        end
    endtask

    task automatic test_async_reset();
        stall_i = 1'b1;
        step();
        checks++;
        if ({stall_cnt_o, imem_addr_o} !== {16'd4, 16'h0000}) begin
            errors++;
            $display("FAIL pre_reset_stall: cnt=%0d addr=%h, expected 4 0000", stall_cnt_o, imem_addr_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_addr_o, if_id_instr_o, if_id_pc2_o, if_id_valid_o, halted_o, stall_cnt_o}
            !== {16'h0000, NOP, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL async_reset: addr=%h instr=%h pc2=%h v=%b h=%b cnt=%h, expected 0000 0800 0000 0 0 0000",
                     imem_addr_o, if_id_instr_o, if_id_pc2_o, if_id_valid_o, halted_o, stall_cnt_o);
        end
        stall_i = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_stall();
        test_redirect_over_stall();
        test_imem_not_ready();
        test_halt();
        test_pc_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
